// File: rtl/fetch_predecode.sv
// Pre-decode stage: 2-entry buffer between fetch and decode with static
// prediction of direct branches, redirecting fetch in the cycle of acceptance.
module fetch_predecode #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        FpD_valid,
  input  logic [74:0] FpD_BUS,
  output logic        pD_allowin,
  output logic [32:0] predict_BUS,
  output logic        BTB_stall,
  input  logic        flush,
  output logic        pDD_valid,
  output logic [75:0] pDD_BUS,
  input  logic        D_allowin
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [75:0] mem [0:1];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;

  logic        push;
  logic        pop;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ex;
  logic [7:0]  in_ecode;
  logic        in_esubcode;
  logic        unused_pc_en;
  logic [5:0]  opcode;
  logic        is_uncond;
  logic        is_cond;
  logic [31:0] offs;
  logic [31:0] target;
  logic        pred;
  logic        backward;
  logic [75:0] entry;

  assign in_pc        = FpD_BUS[74:43];
  assign in_inst      = FpD_BUS[42:11];
  assign unused_pc_en = FpD_BUS[10];
  assign in_ex        = FpD_BUS[9];
  assign in_ecode     = FpD_BUS[8:1];
  assign in_esubcode  = FpD_BUS[0];
  assign opcode       = in_inst[31:26];

  assign pD_allowin = (count != FULL);
  assign BTB_stall  = (count == FULL);
  assign pDD_valid  = (count != 2'd0);
  assign pDD_BUS    = mem[rptr];

  assign push = FpD_valid & pD_allowin & ~flush;
  assign pop  = pDD_valid & D_allowin & ~flush;

  // B/BL always taken; conditional branches taken only when backward
  always_comb begin
    is_uncond = (opcode == 6'b010100) || (opcode == 6'b010101);
    is_cond   = (opcode >= 6'b010110) && (opcode <= 6'b011011);
    offs      = 32'd0;
    if (is_uncond)
      offs = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
    else if (is_cond)
      offs = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
    target   = in_pc + offs;
    pred     = ~in_ex & (is_uncond | (is_cond & offs[31]));
    backward = ~in_ex & (is_uncond | is_cond) & offs[31];
    entry    = {in_pc, in_inst, pred, in_ex, in_ecode, in_esubcode, backward};
  end

  assign predict_BUS = (push & pred) ? {1'b1, target} : 33'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= 76'd0;
      mem[1] <= 76'd0;
    end else if (flush) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= entry;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
